// File: rtl/reg_file_sb.sv
// Integer register file with N combinational read ports, one write port, optional
// write-to-read bypass and a busy-bit scoreboard tracking not-yet-written destinations.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NRD*AW-1:0]     i_raddr,
  output logic [NRD*XLEN-1:0]   o_rdata,
  output logic [NRD-1:0]        o_rbusy,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic                  i_issue,
  input  logic [AW-1:0]         i_issue_rd,
  input  logic                  i_flush,
  output logic [AW:0]           o_pending
);

  localparam int NREGS = 2**AW;

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      pending_reg;
  logic [AW:0]      pending_next;

  genvar gi;

  // One storage word per register; x0 never takes a write when hardwired to zero.
  for (gi = 0; gi < NREGS; gi++) begin : g_reg
    logic wr_hit;
    assign wr_hit = i_we && (i_waddr == AW'(gi)) && !((ZERO_REG != 0) && (gi == 0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        regs_reg[gi] <= '0;
      end else if (wr_hit) begin
        regs_reg[gi] <= i_wdata;
      end
    end
  end

  // Flush dominates; otherwise writeback clears first so a same-register issue wins.
  always_comb begin
    busy_next = busy_reg;
    if (i_flush) begin
      busy_next = '0;
    end else begin
      if (i_we) begin
        busy_next[i_waddr] = 1'b0;
      end
      if (i_issue) begin
        busy_next[i_issue_rd] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  always_comb begin
    pending_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_next = pending_next + {{AW{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_reg    <= '0;
      pending_reg <= '0;
    end else begin
      busy_reg    <= busy_next;
      pending_reg <= pending_next;
    end
  end

  assign o_pending = pending_reg;

  // Outputs are forced quiet while reset is held, even if a write is presented.
  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero_hit;
    logic          byp_hit;

    assign addr     = i_raddr[gi*AW +: AW];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);
    assign byp_hit  = (BYPASS != 0) && i_we && (i_waddr == addr);

    assign o_rdata[gi*XLEN +: XLEN] = (!i_rst_n || zero_hit) ? '0 :
                                      byp_hit                ? i_wdata :
                                                               regs_reg[addr];
    assign o_rbusy[gi] = i_rst_n && !zero_hit && !byp_hit && busy_reg[addr];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: a bypassing and a non-bypassing register file share one stimulus
// stream and are compared every cycle against an array/mask model plus literal checkpoints.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra0, ra1;
  logic [9:0]  raddr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        flush;

  logic [63:0] rdata_b, rdata_nb;
  logic [1:0]  rbusy_b, rbusy_nb;
  logic [5:0]  pend_b, pend_nb;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [31:0] mbusy;

  assign raddr = {ra1, ra0};

  reg_file_sb #(.XLEN(32), .AW(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_b), .o_rbusy(rbusy_b),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_issue(issue), .i_issue_rd(issue_rd),
    .i_flush(flush), .o_pending(pend_b)
  );

  reg_file_sb #(.XLEN(32), .AW(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_nb), .o_rbusy(rbusy_nb),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_issue(issue), .i_issue_rd(issue_rd),
    .i_flush(flush), .o_pending(pend_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: register contents and a busy mask updated by clear-then-set bit masks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      mbusy <= 32'd0;
    end else begin
      if (we && waddr != 5'd0) mregs[waddr] <= wdata;
      if (flush) mbusy <= 32'd0;
      else mbusy <= (mbusy & ~(we ? (32'd1 << waddr) : 32'd0))
                  | ((issue && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0);
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (byp && we && waddr == a) return wdata;
    return mregs[a];
  endfunction

  function automatic logic exp_rbusy(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 1'b0;
    if (byp && we && waddr == a) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a;
      a = (k == 1) ? ra1 : ra0;
      check($sformatf("rdata_byp p%0d a%0d", k, a), {32'd0, rdata_b[k*32 +: 32]}, {32'd0, exp_rdata(a, 1'b1)});
      check($sformatf("rdata_nobyp p%0d a%0d", k, a), {32'd0, rdata_nb[k*32 +: 32]}, {32'd0, exp_rdata(a, 1'b0)});
      check($sformatf("rbusy_byp p%0d a%0d", k, a), {63'd0, rbusy_b[k]}, {63'd0, exp_rbusy(a, 1'b1)});
      check($sformatf("rbusy_nobyp p%0d a%0d", k, a), {63'd0, rbusy_nb[k]}, {63'd0, exp_rbusy(a, 1'b0)});
    end
    check("pending_byp", {58'd0, pend_b}, 64'($countones(mbusy)));
    check("pending_nobyp", {58'd0, pend_nb}, 64'($countones(mbusy)));
  end

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
    $display("cyc t=%0t rst_n=%0b we=%0b wa=%0d wd=%h iss=%0b rd=%0d fl=%0b ra=%0d/%0d pend=%0d",
             $time, rst_n, we, waddr, wdata, issue, issue_rd, flush, ra0, ra1, pend_b);
  endtask

  task automatic idle;
    we = 1'b0; issue = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ra0 = '0; ra1 = '0; we = 1'b0; waddr = '0; wdata = '0;
    issue = 1'b0; issue_rd = '0; flush = 1'b0;
    repeat (2) adv;
    rst_n = 1'b1;

    // Reset readback of every address on both ports
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a);
      adv;
    end
    settle; check("lit pending after reset", {58'd0, pend_b}, 64'd0);
    adv;

    // x0 ignores writes
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; ra0 = 5'd0;
    settle; check("lit x0 bypass masked", {32'd0, rdata_b[31:0]}, 64'd0);
    adv; idle;
    settle; check("lit x0 after write", {32'd0, rdata_nb[31:0]}, 64'd0);
    adv;

    // Bypass vs registered visibility
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; ra0 = 5'd5;
    settle;
    check("lit bypass same cycle", {32'd0, rdata_b[31:0]}, 64'h12345678);
    check("lit nobypass old value", {32'd0, rdata_nb[31:0]}, 64'd0);
    adv; idle;
    settle; check("lit nobypass next cycle", {32'd0, rdata_nb[31:0]}, 64'h12345678);
    adv;

    // Issue then writeback of x7
    issue = 1'b1; issue_rd = 5'd7; ra0 = 5'd7;
    adv; idle;
    settle;
    check("lit x7 busy", {63'd0, rbusy_b[0]}, 64'd1);
    check("lit pending one", {58'd0, pend_b}, 64'd1);
    adv;
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5;
    settle;
    check("lit x7 bypass clears busy", {63'd0, rbusy_b[0]}, 64'd0);
    check("lit x7 nobypass still busy", {63'd0, rbusy_nb[0]}, 64'd1);
    adv; idle;
    settle;
    check("lit pending zero after wb", {58'd0, pend_b}, 64'd0);
    check("lit x7 data", {32'd0, rdata_nb[31:0]}, 64'hA5);
    adv;

    // Same-edge writeback and re-issue of x9
    issue = 1'b1; issue_rd = 5'd9; ra1 = 5'd9;
    adv;
    we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    adv; idle;
    settle;
    check("lit x9 pending kept", {58'd0, pend_b}, 64'd1);
    check("lit x9 still busy", {63'd0, rbusy_b[1]}, 64'd1);
    check("lit x9 new data", {32'd0, rdata_b[63:32]}, 64'h99);
    adv;
    we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    adv; idle;

    // Flush with a competing issue and a data write
    for (int r = 3; r <= 5; r++) begin
      issue = 1'b1; issue_rd = 5'(r);
      adv;
    end
    idle;
    settle; check("lit pending three", {58'd0, pend_b}, 64'd3);
    adv;
    flush = 1'b1; issue = 1'b1; issue_rd = 5'd6; we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE;
    adv; idle; ra0 = 5'd6; ra1 = 5'd12;
    settle;
    check("lit pending flushed", {58'd0, pend_b}, 64'd0);
    check("lit x6 not busy", {63'd0, rbusy_b[0]}, 64'd0);
    check("lit flush keeps write", {32'd0, rdata_b[63:32]}, 64'hCAFE);
    adv;

    // Asynchronous reset between edges
    we = 1'b1; waddr = 5'd10; wdata = 32'h55; issue = 1'b1; issue_rd = 5'd11;
    adv; idle; ra0 = 5'd10; ra1 = 5'd11;
    settle;
    check("lit x10 before reset", {32'd0, rdata_b[31:0]}, 64'h55);
    check("lit x11 busy before reset", {63'd0, rbusy_b[1]}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("lit async rdata byp", {32'd0, rdata_b[31:0]}, 64'd0);
    check("lit async rdata nobyp", {32'd0, rdata_nb[31:0]}, 64'd0);
    check("lit async rbusy", {62'd0, rbusy_b}, 64'd0);
    check("lit async pending", {58'd0, pend_b}, 64'd0);
    adv; rst_n = 1'b1;
    settle; check("lit x10 cleared", {32'd0, rdata_nb[31:0]}, 64'd0);
    adv;

    // Issue to x0 ignored; write to an idle register does not underflow
    issue = 1'b1; issue_rd = 5'd0; we = 1'b1; waddr = 5'd20; wdata = 32'h1234;
    adv; idle;
    settle; check("lit no underflow", {58'd0, pend_b}, 64'd0);
    adv;

    // Pipelined issue/writeback stream checked by the model
    for (int i = 1; i <= 8; i++) begin
      issue = 1'b1; issue_rd = 5'(i);
      we = (i >= 3); waddr = 5'(i - 2); wdata = 32'(i) * 32'h111;
      ra0 = 5'(i - 2); ra1 = 5'(i);
      adv;
    end
    idle;
    repeat (2) adv;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with N combinational read ports, one write port, optional write-to-read bypass and an integrated busy-bit scoreboard. It is the architectural integer register file for the pipelined RISC-V core: decode reads operands and issues destinations, and writeback writes results. The scoreboard flags operands whose producer has not yet written back, so decode can stall on a single output.

## Interface
- XLEN, 32, register data width in bits
- AW, 5, address width; depth NREGS = 2**AW
- NRD, 2, number of read ports (at least 1)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and never becomes busy
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- o_rdata  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- o_rbusy  out  NRD  port k operand is pending (producer not yet written)
- i_we  in  1  write enable
- i_waddr  in  AW  write address
- i_wdata  in  XLEN  write data
- i_issue  in  1  mark i_issue_rd as busy (destination allocated)
- i_issue_rd  in  AW  destination being issued
- i_flush  in  1  synchronous clear of all busy bits (pipeline flush)
- o_pending  out  AW+1  number of busy registers

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit busy vector.
- Write: on posedge with i_we=1, reg[i_waddr] <= i_wdata, except for address 0 when ZERO_REG=1.
- Read (combinational, per port k):
  - address 0 with ZERO_REG=1 -> 0
  - else BYPASS=1, i_we=1 and i_waddr==addr -> i_wdata
  - else reg[addr]
- Busy update at posedge, evaluated in this priority order:
  1. i_flush=1 -> every busy bit <= 0; issue and write-clear are ignored that cycle. The data write still occurs.
  2. Otherwise i_we clears busy[i_waddr], then i_issue sets busy[i_issue_rd]. If both target the same register, set wins: the new producer supersedes the old one.
  3. With ZERO_REG=1, busy[0] is constant 0 and issue to register 0 is ignored.
- o_rbusy[k] = busy[addr_k], masked to 0 when:
  - ZERO_REG=1 and addr_k==0, or
  - BYPASS=1, i_we=1 and i_waddr==addr_k (data is being forwarded).
- Write without prior issue is legal: data is written and the busy bit stays 0.
- Issue to an already-busy register is legal: the bit stays 1 (no counting per register).
- o_pending: registered population count of the busy vector; it equals popcount(busy) at all times, with range 0..NREGS.
  - It changes by -1, 0 or +1 per cycle, or drops to 0 on flush.
  - It must not underflow when a write clears an idle register.

## Timing
- Reset (i_rst_n=0, asynchronous): all registers 0, all busy bits 0, o_pending=0. While reset is held, o_rdata=0 and o_rbusy=0 on every port.
  - Reset asserted mid-operation clears state immediately, without a clock edge.
  - The first write is accepted on the first posedge after deassertion.
- Write latency:
  - BYPASS=1: data is visible on read ports in the same cycle (combinational).
  - BYPASS=0: data is visible from the cycle after the capturing edge.
- Issue latency: o_rbusy rises the cycle after the i_issue edge, and o_pending increments on the same edge.
- Writeback clear: o_rbusy falls in the same cycle when BYPASS=1, otherwise the cycle after.
- Read paths are combinational. There is no read-enable and no handshake: all inputs are sampled every cycle.

## Test plan
- Reset/readback: after reset, read all 32 addresses on both ports -> all 0, o_pending=0. Write 0xDEADBEEF to x0 -> x0 still reads 0.
- Bypass: BYPASS=1, i_we=1, i_waddr=5, i_wdata=0x12345678, i_raddr port0=5 in the same cycle -> o_rdata port0=0x12345678 combinationally. With BYPASS=0 the same stimulus returns the old value 0, then 0x12345678 next cycle.
- Scoreboard:
  - issue rd=7 -> next cycle o_rbusy[0]=1 for raddr 7, o_pending=1
  - write x7=0xA5 -> o_rbusy[0]=0 that cycle (BYPASS=1), o_pending=0 after the edge
- Simultaneous issue/write same register: x9 busy, then i_we to x9 and i_issue rd=9 on one edge -> busy[9] stays 1, o_pending unchanged at 1, x9 holds the new data.
- Flush:
  - issue x3, x4, x5 on consecutive cycles -> o_pending=3
  - i_flush with i_issue rd=6 -> all busy 0, o_pending=0, x6 not busy
- Async reset mid-run: with x10=0x55 and x11 busy, pulse i_rst_n low between clock edges -> o_rdata for x10 reads 0 and o_rbusy=0 immediately, o_pending=0.
